// File: rtl/ulx3s_pll_pkg.sv
// Shared definitions for the ULX3S PLL dynamic-phase controller: FSM states,
// PHASESEL output-select codes and a constant helper for counter sizing.
package ulx3s_pll_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    SETUP     = 3'd2,
    PULSE     = 3'd3,
    GAP       = 3'd4,
    SETTLE    = 3'd5
  } state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ulx3s_pll_phase_ctrl_if.sv
// Phase-step request channel between a requester (master) and the controller (slave).
// Handshake: a request transfers on a rising clock edge where req_valid and req_ready
// are both 1; req_sel/req_dir/req_steps are only sampled on that edge.
interface ulx3s_pll_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [3:0] req_steps;

  modport master (output req_valid, output req_sel, output req_dir, output req_steps,
                  input  req_ready);
  modport slave  (input  req_valid, input  req_sel, input  req_dir, input  req_steps,
                  output req_ready);
endinterface

// File: rtl/ulx3s_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset; output reads 0 in reset.
module ulx3s_sync2 (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ulx3s_pll_phase_ctrl.sv
// Sequences ECP5 PLL dynamic phase steps (PHASESEL/PHASEDIR/PHASESTEP) and gates a
// downstream reset on a stable, synchronized PLL lock.
module ulx3s_pll_phase_ctrl
  import ulx3s_pll_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 8,
  parameter int STABLE_CYC = 1024
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pll_locked,
  ulx3s_pll_phase_ctrl_if.slave req,
  output logic [1:0]            phasesel,
  output logic                  phasedir,
  output logic                  phasestep,
  output logic                  phaseloadreg,
  output logic                  busy,
  output logic                  done,
  output logic                  sys_resetn,
  output logic                  lock_lost,
  output state_t                dbgState
);
  localparam int CW = $clog2(maxOf(maxOf(SETUP_CYC, PULSE_CYC), maxOf(GAP_CYC, STABLE_CYC))) + 1;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] STABLE_LD = CW'(STABLE_CYC - 1);

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [4:0]    stepCnt, stepNext;
  logic [1:0]    selNext;
  logic          dirNext, sysRstNext, lostNext, lk;

  ulx3s_sync2 uLockSync (.clock(clock), .resetn(resetn), .d(pll_locked), .q(lk));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      stepCnt    <= '0;
      phasesel   <= SEL_CLKOS;
      phasedir   <= 1'b0;
      sys_resetn <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      stepCnt    <= stepNext;
      phasesel   <= selNext;
      phasedir   <= dirNext;
      sys_resetn <= sysRstNext;
      lock_lost  <= lostNext;
    end
  end

  // The lock-stability counter counts down from STABLE_CYC-1 and is reloaded while
  // lk is low; lk is 0 for the first cycles after reset, so it is always armed.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    stepNext   = stepCnt;
    selNext    = phasesel;
    dirNext    = phasedir;
    sysRstNext = sys_resetn;
    lostNext   = lock_lost;
    done       = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (!lk) cntNext = STABLE_LD;
        else if (cnt == '0) begin
          stateNext  = IDLE;
          sysRstNext = 1'b1;
        end else cntNext = cnt - 1'b1;
      end
      IDLE: begin
        if (!lk) begin
          lostNext   = 1'b1;
          sysRstNext = 1'b0;
          cntNext    = STABLE_LD;
          stateNext  = WAIT_LOCK;
        end else if (req.req_valid) begin
          selNext   = req.req_sel;
          dirNext   = req.req_dir;
          stepNext  = (req.req_steps == 4'd0) ? 5'd16 : {1'b0, req.req_steps};
          cntNext   = SETUP_LD;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          cntNext   = PULSE_LD;
          stateNext = PULSE;
        end else cntNext = cnt - 1'b1;
      end
      PULSE: begin
        if (cnt == '0) begin
          cntNext   = GAP_LD;
          stepNext  = (stepCnt != 5'd0) ? stepCnt - 5'd1 : 5'd0;
          stateNext = GAP;
        end else cntNext = cnt - 1'b1;
      end
      GAP: begin
        if (cnt != '0) cntNext = cnt - 1'b1;
        else if (stepCnt != 5'd0) begin
          cntNext   = PULSE_LD;
          stateNext = PULSE;
        end else begin
          cntNext   = STABLE_LD;
          stateNext = SETTLE;
        end
      end
      SETTLE: begin
        if (!lk) cntNext = STABLE_LD;
        else if (cnt == '0) begin
          done      = 1'b1;
          stateNext = IDLE;
        end else cntNext = cnt - 1'b1;
      end
      default: stateNext = WAIT_LOCK;
    endcase
    // The PLL tolerates a lock glitch mid-step, so the sequence runs on; only flag it.
    if ((state == SETUP || state == PULSE || state == GAP) && !lk) lostNext = 1'b1;
  end

  assign req.req_ready  = (state == IDLE) && lk;
  assign busy           = (state == SETUP) || (state == PULSE) || (state == GAP) || (state == SETTLE);
  assign phasestep      = (state != PULSE);
  assign phaseloadreg   = 1'b1;
  assign dbgState       = state;
endmodule
